// File: rtl/imem_loader_if.sv
// Byte-stream and IMEM write-port bundle for the instruction-memory loader.
// The host side (master) drives the byte stream and reload; the loader (slave) drives the rest.
interface imem_loader_if #(
  parameter int AWIDTH = 32,
  parameter int IWIDTH = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              reload;
  logic              ILoad;
  logic [AWIDTH-1:0] IAddr;
  logic [IWIDTH-1:0] instW;
  logic              core_rst;
  logic              done;
  logic              err;

  modport master (
    output byte_valid, byte_data, reload,
    input  byte_ready, ILoad, IAddr, instW, core_rst, done, err
  );

  modport slave (
    input  byte_valid, byte_data, reload,
    output byte_ready, ILoad, IAddr, instW, core_rst, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Program-load writer: turns a header-prefixed little-endian byte stream into IMEM word
// writes and holds the processor in reset until the whole image has been written.
module imem_loader #(
  parameter int                IWIDTH    = 32,
  parameter int                AWIDTH    = 32,
  parameter int                MAX_WORDS = 1024,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam int WIDX = $clog2(MAX_WORDS) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]        state_q,    state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [IWIDTH-1:0] asm_q,      asm_d;
  logic [WIDX-1:0]   word_idx_q, word_idx_d;
  logic [WIDX-1:0]   nwords_q,   nwords_d;
  logic              iload_q,    iload_d;
  logic [AWIDTH-1:0] iaddr_q,    iaddr_d;
  logic [IWIDTH-1:0] instw_q,    instw_d;

  logic              byte_ready;
  logic              byte_fire;
  logic              last_byte;
  logic              hdr_bad;
  logic              last_word;
  logic [IWIDTH-1:0] asm_next;
  logic [AWIDTH-1:0] word_addr;

  assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
  assign byte_fire  = bus.byte_valid && byte_ready;
  assign last_byte  = byte_fire && (byte_cnt_q == 2'd3);

  // Bytes enter at the top and shift down, so the first byte ends up in bits [7:0].
  assign asm_next  = {bus.byte_data, asm_q[IWIDTH-1:8]};
  assign hdr_bad   = (asm_next == '0) || (asm_next > IWIDTH'(MAX_WORDS));
  assign last_word = (word_idx_q == nwords_q - WIDX'(1));
  assign word_addr = BASE_ADDR + (AWIDTH'(word_idx_q) << 2);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    word_idx_d = word_idx_q;
    nwords_d   = nwords_q;
    iload_d    = 1'b0;
    iaddr_d    = iaddr_q;
    instw_d    = instw_q;

    case (state_q)
      S_IDLE: state_d = S_HDR;

      S_HDR: begin
        if (byte_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = asm_next;
        end
        if (last_byte) begin
          asm_d = '0;
          if (hdr_bad) begin
            state_d = S_ERR;
          end else begin
            nwords_d   = asm_next[WIDX-1:0];
            word_idx_d = '0;
            state_d    = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (byte_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = asm_next;
        end
        if (last_byte) begin
          iload_d = 1'b1;
          iaddr_d = word_addr;
          instw_d = asm_next;
          asm_d   = '0;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        word_idx_d = word_idx_q + WIDX'(1);
        state_d    = last_word ? S_DONE : S_DATA;
      end

      S_DONE, S_ERR: begin
        // A new image always starts from a clean header; stale partial state is dropped.
        if (bus.reload) begin
          state_d    = S_HDR;
          byte_cnt_d = '0;
          asm_d      = '0;
          word_idx_d = '0;
          nwords_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      word_idx_q <= '0;
      nwords_q   <= '0;
      iload_q    <= 1'b0;
      iaddr_q    <= '0;
      instw_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      word_idx_q <= word_idx_d;
      nwords_q   <= nwords_d;
      iload_q    <= iload_d;
      iaddr_q    <= iaddr_d;
      instw_q    <= instw_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.ILoad      = iload_q;
  assign bus.IAddr      = iaddr_q;
  assign bus.instW      = instw_q;
  assign bus.core_rst   = (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, throttled, rejected-header, mid-load reset and
// reload scenarios, with IMEM writes captured by a monitor and compared against hand values.
module tb_imem_loader;

  localparam int AW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always #5 clk = ~clk;

  imem_loader_if #(.AWIDTH(AW), .IWIDTH(IW)) bus ();

  imem_loader #(
    .IWIDTH(IW), .AWIDTH(AW), .MAX_WORDS(1024), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Capture every IMEM write; the loader must be closed to bytes and the core held in reset.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.ILoad === 1'b1) begin
      wr_addr.push_back(bus.IAddr);
      wr_data.push_back(bus.instW);
      checks++;
      if (bus.byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_byte_ready: got %b want 0", bus.byte_ready);
      end
      checks++;
      if (bus.core_rst !== 1'b1) begin
        errors++;
        $display("FAIL write_core_rst: got %b want 1", bus.core_rst);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end else begin
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit throttle);
    foreach (s[i]) begin
      if (throttle) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          bus.byte_valid = 1'b0;
          bus.byte_data  = 8'($urandom_range(0, 255));
          @(negedge clk);
        end
      end
      send_byte(s[i]);
    end
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (bus.done !== 1'b1 && bus.err !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #12;
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.byte_ready); end
    checks++; if (bus.ILoad !== 1'b0) begin errors++; $display("FAIL reset_iload: got %b want 0", bus.ILoad); end
    checks++; if (bus.IAddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", bus.IAddr); end
    checks++; if (bus.instW !== 32'h0) begin errors++; $display("FAIL reset_instw: got %h want 0", bus.instW); end
    checks++; if (bus.core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", bus.core_rst); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_flags: done=%b err=%b want 0 0", bus.done, bus.err); end
    @(negedge clk);
    rst = 1'b1;
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", bus.byte_ready); end
    @(negedge clk);
    checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL hdr_ready: got %b want 1", bus.byte_ready); end
  endtask

  task automatic check_two_words(input string tag);
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL %s_count: got %0d writes want 2", tag, wr_addr.size()); end
    checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00000013) begin errors++; $display("FAIL %s_word0: got %h@%h want 00000013@00000000", tag, wr_data[0], wr_addr[0]); end
    checks++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00500093) begin errors++; $display("FAIL %s_word1: got %h@%h want 00500093@00000004", tag, wr_data[1], wr_addr[1]); end
    checks++; if (bus.done !== 1'b1 || bus.core_rst !== 1'b0) begin errors++; $display("FAIL %s_done: done=%b core_rst=%b want 1 0", tag, bus.done, bus.core_rst); end
    checks++; if (bus.byte_ready !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL %s_idle: ready=%b err=%b want 0 0", tag, bus.byte_ready, bus.err); end
    checks++; if (bus.ILoad !== 1'b0 || bus.IAddr !== 32'h4 || bus.instW !== 32'h00500093) begin errors++; $display("FAIL %s_hold: iload=%b iaddr=%h instw=%h want 0 4 00500093", tag, bus.ILoad, bus.IAddr, bus.instW); end
  endtask

  task automatic test_basic_load();
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    wr_addr.delete(); wr_data.delete();
    send_stream(s, 1'b0);
    wait_end(20);
    @(negedge clk);
    check_two_words("basic");
  endtask

  task automatic test_throttled();
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    pulse_reload();
    checks++; if (bus.core_rst !== 1'b1 || bus.done !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL reload_hdr: core_rst=%b done=%b ready=%b want 1 0 1", bus.core_rst, bus.done, bus.byte_ready); end
    wr_addr.delete(); wr_data.delete();
    send_stream(s, 1'b1);
    wait_end(20);
    @(negedge clk);
    check_two_words("throttled");
  endtask

  task automatic test_zero_header();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h00, 8'h00};
    pulse_reload();
    wr_addr.delete(); wr_data.delete();
    send_stream(s, 1'b0);
    wait_end(20);
    @(negedge clk);
    checks++; if (bus.err !== 1'b1 || bus.core_rst !== 1'b1) begin errors++; $display("FAIL zero_err: err=%b core_rst=%b want 1 1", bus.err, bus.core_rst); end
    checks++; if (bus.byte_ready !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL zero_idle: ready=%b done=%b want 0 0", bus.byte_ready, bus.done); end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
    pulse_reload();
    checks++; if (bus.err !== 1'b0 || bus.byte_ready !== 1'b1 || bus.core_rst !== 1'b1) begin errors++; $display("FAIL zero_reload: err=%b ready=%b core_rst=%b want 0 1 1", bus.err, bus.byte_ready, bus.core_rst); end
  endtask

  task automatic test_oversize_header();
    logic [7:0] s[$];
    s = '{8'h01, 8'h04, 8'h00, 8'h00};
    wr_addr.delete(); wr_data.delete();
    send_stream(s, 1'b0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (4) @(negedge clk);
    checks++; if (bus.err !== 1'b1 || bus.byte_ready !== 1'b0) begin errors++; $display("FAIL big_err: err=%b ready=%b want 1 0", bus.err, bus.byte_ready); end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL big_writes: got %0d want 0", wr_addr.size()); end
    bus.byte_valid = 1'b0;
    pulse_reload();
    checks++; if (bus.err !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL big_reload: err=%b ready=%b want 0 1", bus.err, bus.byte_ready); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] s[$];
    s = '{8'h00, 8'h04, 8'h00, 8'h00};
    send_stream(s, 1'b0);
    checks++; if (bus.err !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL max_hdr: err=%b ready=%b want 0 1", bus.err, bus.byte_ready); end
    send_byte(8'h55);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.ILoad !== 1'b0 || bus.IAddr !== 32'h0 || bus.instW !== 32'h0) begin errors++; $display("FAIL mid_rst_bus: iload=%b iaddr=%h instw=%h want 0 0 0", bus.ILoad, bus.IAddr, bus.instW); end
    checks++; if (bus.byte_ready !== 1'b0 || bus.core_rst !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: ready=%b core_rst=%b done=%b err=%b want 0 1 0 0", bus.byte_ready, bus.core_rst, bus.done, bus.err); end
    @(negedge clk);
    rst = 1'b1;
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr_addr.delete(); wr_data.delete();
    send_stream(s, 1'b0);
    wait_end(20);
    checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_rst_load: n=%0d got %h@%h want DEADBEEF@00000000", wr_addr.size(), wr_data[0], wr_addr[0]); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mid_rst_done: got %b want 1", bus.done); end
  endtask

  task automatic test_reload();
    logic [7:0] s[$];
    pulse_reload();
    checks++; if (bus.core_rst !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL rl_start: core_rst=%b done=%b want 1 0", bus.core_rst, bus.done); end
    wr_addr.delete(); wr_data.delete();
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78};
    send_stream(s, 1'b0);
    pulse_reload();
    checks++; if (bus.byte_ready !== 1'b1 || bus.err !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rl_ignored: ready=%b err=%b done=%b want 1 0 0", bus.byte_ready, bus.err, bus.done); end
    s = '{8'h56, 8'h34, 8'h12};
    send_stream(s, 1'b0);
    wait_end(20);
    checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h12345678) begin errors++; $display("FAIL rl_load: n=%0d got %h@%h want 12345678@00000000", wr_addr.size(), wr_data[0], wr_addr[0]); end
    checks++; if (bus.done !== 1'b1 || bus.core_rst !== 1'b0) begin errors++; $display("FAIL rl_done: done=%b core_rst=%b want 1 0", bus.done, bus.core_rst); end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.reload     = 1'b0;
    test_reset();
    test_basic_load();
    test_throttled();
    test_zero_header();
    test_oversize_header();
    test_reset_midload();
    test_reload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
